// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: state codes,
// opcodes and datapath mux/ALU select codes.
package multicycle_pkg;

   localparam int unsigned STATE_BITS = 4;
   localparam int unsigned OPC_BITS   = 6;

   typedef enum logic [STATE_BITS-1:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EX   = 4'd10,
      ADDI_WB   = 4'd11
   } state_e;

   localparam logic [OPC_BITS-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_BITS-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_BITS-1:0] OP_SW    = 6'b101011;
   localparam logic [OPC_BITS-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_BITS-1:0] OP_J     = 6'b000010;
   localparam logic [OPC_BITS-1:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic op_supported(input logic [OPC_BITS-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_out.sv
// Combinational state-to-control decoder. Every datapath strobe and select
// is a pure function of the current state; unlisted fields stay 0.
module multicycle_ctrl_out
   import multicycle_pkg::*;
(
   input  logic [STATE_BITS-1:0] i_state,
   output logic                  o_pc_write,
   output logic                  o_pc_write_cond,
   output logic                  o_iord,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_ir_write,
   output logic                  o_mem_to_reg,
   output logic                  o_reg_dst,
   output logic                  o_reg_write,
   output logic                  o_alu_src_a,
   output logic [1:0]            o_alu_src_b,
   output logic [1:0]            o_alu_op,
   output logic [1:0]            o_pc_source
);

   always_comb begin
      o_pc_write      = 1'b0;
      o_pc_write_cond = 1'b0;
      o_iord          = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_ir_write      = 1'b0;
      o_mem_to_reg    = 1'b0;
      o_reg_dst       = 1'b0;
      o_reg_write     = 1'b0;
      o_alu_src_a     = 1'b0;
      o_alu_src_b     = SRCB_B;
      o_alu_op        = ALU_ADD;
      o_pc_source     = PCSRC_ALU;

      case (i_state)
         FETCH: begin
            o_mem_read  = 1'b1;
            o_ir_write  = 1'b1;
            o_pc_write  = 1'b1;
            o_alu_src_b = SRCB_FOUR;
         end
         // Speculative branch target lands in ALUOut for BRANCH to use.
         DECODE: begin
            o_alu_src_b = SRCB_IMM_SH2;
         end
         MEM_ADDR: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRCB_IMM;
         end
         MEM_READ: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         MEM_WB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         EXECUTE: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALU_FUNCT;
         end
         R_WB: begin
            o_reg_write = 1'b1;
            o_reg_dst   = 1'b1;
         end
         BRANCH: begin
            o_alu_src_a     = 1'b1;
            o_alu_op        = ALU_SUB;
            o_pc_write_cond = 1'b1;
            o_pc_source     = PCSRC_ALUOUT;
         end
         JUMP: begin
            o_pc_write  = 1'b1;
            o_pc_source = PCSRC_JUMP;
         end
         ADDI_EX: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRCB_IMM;
         end
         ADDI_WB: begin
            o_reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU: state register, opcode-driven
// next-state logic and the illegal-opcode flag; outputs come from the decoder.
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int unsigned STATE_W = 4,
   parameter int unsigned OP_W    = 6
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [OP_W-1:0]    i_opcode,
   output logic               o_pc_write,
   output logic               o_pc_write_cond,
   output logic               o_iord,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic               o_ir_write,
   output logic               o_mem_to_reg,
   output logic               o_reg_dst,
   output logic               o_reg_write,
   output logic               o_alu_src_a,
   output logic [1:0]         o_alu_src_b,
   output logic [1:0]         o_alu_op,
   output logic [1:0]         o_pc_source,
   output logic               o_illegal,
   output logic [STATE_W-1:0] o_state
);

   state_e state_q, state_d;

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            if (i_opcode == OP_LW || i_opcode == OP_SW) state_d = MEM_ADDR;
            else if (i_opcode == OP_RTYPE)              state_d = EXECUTE;
            else if (i_opcode == OP_BEQ)                state_d = BRANCH;
            else if (i_opcode == OP_J)                  state_d = JUMP;
            else if (i_opcode == OP_ADDI)               state_d = ADDI_EX;
            else                                        state_d = FETCH;
         end
         // IR cannot change here, so a non-memory opcode only appears on a
         // corrupted IR; abandon the instruction rather than guess.
         MEM_ADDR: begin
            if (i_opcode == OP_LW)      state_d = MEM_READ;
            else if (i_opcode == OP_SW) state_d = MEM_WRITE;
            else                        state_d = FETCH;
         end
         MEM_READ: state_d = MEM_WB;
         EXECUTE:  state_d = R_WB;
         ADDI_EX:  state_d = ADDI_WB;
         default:  state_d = FETCH;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= FETCH;
      else         state_q <= state_d;
   end

   assign o_state   = STATE_W'(state_q);
   assign o_illegal = (state_q == DECODE) && !op_supported(i_opcode);

   multicycle_ctrl_out u_out (
      .i_state         (state_q),
      .o_pc_write      (o_pc_write),
      .o_pc_write_cond (o_pc_write_cond),
      .o_iord          (o_iord),
      .o_mem_read      (o_mem_read),
      .o_mem_write     (o_mem_write),
      .o_ir_write      (o_ir_write),
      .o_mem_to_reg    (o_mem_to_reg),
      .o_reg_dst       (o_reg_dst),
      .o_reg_write     (o_reg_write),
      .o_alu_src_a     (o_alu_src_a),
      .o_alu_src_b     (o_alu_src_b),
      .o_alu_op        (o_alu_op),
      .o_pc_source     (o_pc_source)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction table, reset
// abort, model-checked random instruction stream and a random invariant run.
module tb_multicycle_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   multicycle_ctrl #(.STATE_W(4), .OP_W(6)) dut (
      .i_clk           (clk),
      .i_reset         (rst),
      .i_opcode        (opcode),
      .o_pc_write      (pc_write),
      .o_pc_write_cond (pc_write_cond),
      .o_iord          (iord),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .o_ir_write      (ir_write),
      .o_mem_to_reg    (mem_to_reg),
      .o_reg_dst       (reg_dst),
      .o_reg_write     (reg_write),
      .o_alu_src_a     (alu_src_a),
      .o_alu_src_b     (alu_src_b),
      .o_alu_op        (alu_op),
      .o_pc_source     (pc_source),
      .o_illegal       (illegal),
      .o_state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
   } out_t;

   // seq holds the expected state path, one hex digit per cycle, low first.
   typedef struct packed {
      logic [5:0]       op;
      logic [2:0]       n;
      logic [5:0][3:0]  seq;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic known_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
   endfunction

   // Expected control word for each state, straight from the state table.
   function automatic out_t exp_out(input int st, input logic [5:0] op);
      out_t o;
      o = '0;
      case (st)
         0:  begin o.mem_read = 1; o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'b01; end
         1:  begin o.alu_src_b = 2'b11; o.illegal = !known_op(op); end
         2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         3:  begin o.mem_read = 1; o.iord = 1; end
         4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         5:  begin o.mem_write = 1; o.iord = 1; end
         6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         7:  begin o.reg_write = 1; o.reg_dst = 1; end
         8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                   o.pc_source = 2'b01; end
         9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
         10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         11: begin o.reg_write = 1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic out_t act_out();
      out_t o;
      o = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
      return o;
   endfunction

   // Instruction-level model: every instruction is fetch, decode, then a
   // class-specific tail; the result is the list of states visited.
   task automatic model_path(input logic [5:0] op, output logic [5:0][3:0] seq,
                             output logic [2:0] n);
      int q[$];
      q = {0, 1};
      if (op == 6'b100011)      q = {q, 2, 3, 4};
      else if (op == 6'b101011) q = {q, 2, 5};
      else if (op == 6'b000000) q = {q, 6, 7};
      else if (op == 6'b000100) q = {q, 8};
      else if (op == 6'b000010) q = {q, 9};
      else if (op == 6'b001000) q = {q, 10, 11};
      seq = '0;
      foreach (q[i]) seq[i] = q[i][3:0];
      n = 3'(q.size());
   endtask

   task automatic run_seq(input string tag, input logic [5:0] op, input logic [2:0] n,
                          input logic [5:0][3:0] seq);
      opcode = op;
      for (int k = 0; k < int'(n); k++) begin
         check($sformatf("%s state[%0d]", tag, k), 32'(state), 32'(seq[k]));
         check($sformatf("%s outs[%0d]", tag, k), 32'(act_out()),
               32'(exp_out(int'(seq[k]), op)));
         tick();
      end
   endtask

   vec_t vecs[8];

   initial begin
      logic [5:0][3:0] mseq;
      logic [2:0]      mn;
      logic [5:0]      rop;
      logic [5:0]      pool[6];

      vecs[0] = '{op: 6'b100011, n: 3'd5, seq: 24'h043210};
      vecs[1] = '{op: 6'b101011, n: 3'd4, seq: 24'h005210};
      vecs[2] = '{op: 6'b000000, n: 3'd4, seq: 24'h007610};
      vecs[3] = '{op: 6'b000100, n: 3'd3, seq: 24'h000810};
      vecs[4] = '{op: 6'b000010, n: 3'd3, seq: 24'h000910};
      vecs[5] = '{op: 6'b001000, n: 3'd4, seq: 24'h00ba10};
      vecs[6] = '{op: 6'b111111, n: 3'd2, seq: 24'h000010};
      vecs[7] = '{op: 6'b000001, n: 3'd2, seq: 24'h000010};
      pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

      // Reset state, with an illegal opcode present to show o_illegal stays low.
      rst    = 1'b1;
      opcode = 6'b111111;
      #2;
      check("reset state", 32'(state), 32'd0);
      check("reset outs", 32'(act_out()), 32'(exp_out(0, opcode)));
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 8; v++)
         run_seq($sformatf("vec%0d", v), vecs[v].op, vecs[v].n, vecs[v].seq);
      check("table end state", 32'(state), 32'd0);

      // Reset abort while in MEM_READ, asynchronous to the clock.
      opcode = 6'b100011;
      tick(); tick(); tick();
      check("pre-abort state", 32'(state), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("abort state", 32'(state), 32'd0);
      check("abort outs", 32'(act_out()), 32'(exp_out(0, opcode)));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-release outs", 32'(act_out()), 32'(exp_out(0, opcode)));
      tick();
      check("first edge state", 32'(state), 32'd1);
      tick(); tick(); tick(); tick();
      check("lw after abort done", 32'(state), 32'd0);

      // Random instruction stream against the model; opcode held per instruction.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(3) != 0) rop = pool[$urandom_range(5)];
         else                        rop = 6'($urandom);
         model_path(rop, mseq, mn);
         run_seq($sformatf("rnd%0d op%02h", i, rop), rop, mn, mseq);
      end

      // Opcode changes every cycle: only structural invariants are claimed.
      for (int i = 0; i < 1000; i++) begin
         opcode = 6'($urandom);
         #1;
         check($sformatf("inv mem rd&wr %0d", i), 32'(mem_read & mem_write), 32'd0);
         check($sformatf("inv pc wr&cond %0d", i), 32'(pc_write & pc_write_cond), 32'd0);
         check($sformatf("inv state range %0d", i), 32'(state <= 4'd11), 32'd1);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
